instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 85 ++++++++
 tb/tb_instr_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding fetch FSM feeding a circular instruction queue for the decoder
module instr_fetch #(
    parameter int QUEUE_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_instr,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;
    state_t state;
    logic [31:0] fetch_pc;
    logic [PW-1:0] head, tail;
    logic [PW:0] count;
    logic [31:0] instr_q [QUEUE_DEPTH];
    logic [31:0] pc_q [QUEUE_DEPTH];
    logic enq, deq;
    logic [31:0] jimm, next_pc;
    assign dec_valid = count != '0;
    assign dec_instr = instr_q[head];
    assign dec_pc = pc_q[head];
    // queue handshakes and the fetch address following the returned instruction (JAL or +4)
    always_comb begin
        enq = state == WAIT && icache_resp_valid && !flush_in;
        deq = dec_valid && dec_ready && !flush_in;
        jimm = {{11{icache_resp_instr[31]}}, icache_resp_instr[31], icache_resp_instr[19:12],
                icache_resp_instr[20], icache_resp_instr[30:21], 1'b0};
        next_pc = fetch_pc + (icache_resp_instr[6:0] == 7'b1101111 ? jimm : 32'd4);
    end
    // queue storage; contents are don't-care until written
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && enq) begin
            instr_q[tail] <= icache_resp_instr;
            pc_q[tail] <= fetch_pc;
        end
    end
    // fetch FSM and queue pointers; flush overrides everything except reset and stall
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= FETCH;
            fetch_pc <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            icache_req_valid <= 1'b0;
            icache_req_addr <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head <= '0;
                tail <= '0;
                count <= '0;
                fetch_pc <= flush_pc;
                icache_req_valid <= 1'b0;
                state <= state != FETCH && !icache_resp_valid ? DISCARD : FETCH;
            end else begin
                head <= head + PW'(deq);
                tail <= tail + PW'(enq);
                count <= count + (PW+1)'(enq) - (PW+1)'(deq);
                case (state)
                    FETCH: if (!count[PW]) begin
                        state <= WAIT;
                        icache_req_valid <= 1'b1;
                        icache_req_addr <= fetch_pc;
                    end
                    WAIT: if (icache_resp_valid) begin
                        state <= FETCH;
                        icache_req_valid <= 1'b0;
                        fetch_pc <= next_pc;
                    end
                    default: if (icache_resp_valid) state <= FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: cache model plus scoreboard of expected decoder entries, with directed scenarios
module tb_instr_fetch;
    logic clk = 0, rst_in = 1, rdy_in = 1, flush_in = 0, dec_ready = 0;
    logic [31:0] flush_pc = 0;
    logic icache_req_valid, dec_valid;
    logic icache_resp_valid = 0;
    logic [31:0] icache_req_addr, dec_instr, dec_pc;
    logic [31:0] icache_resp_instr = 0;
    int checks = 0, failures = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_i[$], exp_p[$], req_log[$], pop_pcs[$], pop_instrs[$];
    int lat = 2, cnt = 0;
    bit cache_en = 1, busy = 0, live = 0;
    logic [31:0] addr_l = 0;
    logic dv_seen;

    instr_fetch #(.QUEUE_DEPTH(8)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
        .icache_resp_valid(icache_resp_valid), .icache_resp_instr(icache_resp_instr),
        .flush_in(flush_in), .flush_pc(flush_pc),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h00000013;
    endfunction

    // cache model on the falling edge, then the scoreboard predicts the coming rising edge
    always @(negedge clk) begin
        if (rst_in) begin
            busy = 0;
            icache_resp_valid = 0;
        end else if (cache_en) begin
            icache_resp_valid = 0;
            if (busy) begin
                if (cnt == 0) begin
                    icache_resp_valid = 1;
                    icache_resp_instr = fetch_word(addr_l);
                    busy = 0;
                end else cnt--;
            end else if (icache_req_valid) begin
                busy = 1;
                cnt = lat - 1;
                addr_l = icache_req_addr;
                live = 1;
                req_log.push_back(addr_l);
            end
        end
        #2;
        if (rst_in) begin
            live = 0;
            exp_i.delete();
            exp_p.delete();
        end else if (rdy_in) begin
            if (dec_valid && dec_ready && !flush_in) begin
                chk("sb_nonempty", 32'(exp_i.size() != 0), 1);
                if (exp_i.size() != 0) begin
                    chk("dec_instr", dec_instr, exp_i.pop_front());
                    chk("dec_pc", dec_pc, exp_p.pop_front());
                end
                pop_pcs.push_back(dec_pc);
                pop_instrs.push_back(dec_instr);
            end
            if (flush_in) begin
                live = 0;
                exp_i.delete();
                exp_p.delete();
            end else if (icache_resp_valid && live) begin
                exp_i.push_back(icache_resp_instr);
                exp_p.push_back(addr_l);
                live = 0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int n);
        for (int i = 0; i < 200 && req_log.size() < n; i++) tick();
        chk("wait_req", 32'(req_log.size() >= n), 1);
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 300 && pop_pcs.size() < n; i++) tick();
        chk("wait_pops", 32'(pop_pcs.size() >= n), 1);
    endtask

    task automatic do_reset();
        rst_in = 1;
        tick();
        rst_in = 0;
        req_log.delete();
        pop_pcs.delete();
        pop_instrs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tick();
        chk("rst_req_valid", 32'(icache_req_valid), 0);
        chk("rst_req_addr", icache_req_addr, 0);
        chk("rst_dec_valid", 32'(dec_valid), 0);
        do_reset();
        lat = 2;
        dec_ready = 1;
        wait_pops(3);
        chk("seq_req0", req_log[0], 32'h0);
        chk("seq_req1", req_log[1], 32'h4);
        chk("seq_req2", req_log[2], 32'h8);
        chk("seq_pc0", pop_pcs[0], 32'h0);
        chk("seq_pc1", pop_pcs[1], 32'h4);
        chk("seq_pc2", pop_pcs[2], 32'h8);
        chk("seq_instr0", pop_instrs[0], 32'h00000013);

        mem[0] = 32'h008000EF;
        do_reset();
        wait_req(3);
        chk("jal_target", req_log[1], 32'h8);
        chk("jal_after", req_log[2], 32'hC);
        wait_pops(1);
        chk("jal_instr", pop_instrs[0], 32'h008000EF);
        chk("jal_pc", pop_pcs[0], 32'h0);
        mem.delete(0);

        dec_ready = 0;
        do_reset();
        lat = 1;
        tick(40);
        chk("full_reqs", req_log.size(), 8);
        chk("full_rv", 32'(icache_req_valid), 0);
        chk("full_dv", 32'(dec_valid), 1);
        dec_ready = 1;
        tick();
        dec_ready = 0;
        tick(10);
        chk("pulse_reqs", req_log.size(), 9);
        chk("pulse_addr", req_log[8], 32'h20);
        chk("pulse_rv", 32'(icache_req_valid), 0);
        dec_ready = 1;
        wait_pops(9);
        chk("full_last_pc", pop_pcs[8], 32'h20);
        dec_ready = 0;

        do_reset();
        lat = 3;
        mem[0] = 32'h0BADF00D;
        for (int i = 0; i < 50 && !icache_req_valid; i++) tick();
        chk("wait_rv", 32'(icache_req_valid), 1);
        flush_pc = 32'h100;
        flush_in = 1;
        tick();
        flush_in = 0;
        chk("disc_rv", 32'(icache_req_valid), 0);
        chk("disc_dv", 32'(dec_valid), 0);
        dv_seen = 0;
        for (int i = 0; i < 200 && req_log.size() < 2; i++) begin
            tick();
            dv_seen |= dec_valid;
        end
        chk("disc_dv_hold", 32'(dv_seen), 0);
        chk("flush_addr", req_log[1], 32'h100);
        dec_ready = 1;
        wait_pops(1);
        chk("flush_pc0", pop_pcs[0], 32'h100);
        chk("flush_instr0", pop_instrs[0], 32'h00000013);
        dec_ready = 0;
        mem.delete(0);

        do_reset();
        lat = 2;
        wait_req(2);
        for (int i = 0; i < 50 && !icache_resp_valid; i++) begin
            @(negedge clk);
            #1;
        end
        chk("sim_resp_seen", 32'(icache_resp_valid), 1);
        chk("sim_dv_before", 32'(dec_valid), 1);
        flush_pc = 32'hFFFFFFFC;
        flush_in = 1;
        dec_ready = 1;
        tick();
        flush_in = 0;
        dec_ready = 0;
        chk("sim_dv", 32'(dec_valid), 0);
        chk("sim_rv", 32'(icache_req_valid), 0);
        wait_req(3);
        chk("sim_addr", req_log[2], 32'hFFFFFFFC);
        dec_ready = 1;
        wait_pops(2);
        chk("wrap_pc0", pop_pcs[0], 32'hFFFFFFFC);
        chk("wrap_pc1", pop_pcs[1], 32'h0);
        dec_ready = 0;

        do_reset();
        lat = 2;
        wait_req(2);
        rdy_in = 0;
        cache_en = 0;
        dec_ready = 1;
        flush_pc = 32'h300;
        flush_in = 1;
        tick(5);
        chk("stall_rv", 32'(icache_req_valid), 1);
        chk("stall_addr", icache_req_addr, 32'h4);
        chk("stall_dv", 32'(dec_valid), 1);
        chk("stall_pc", dec_pc, 32'h0);
        chk("stall_instr", dec_instr, 32'h00000013);
        rdy_in = 1;
        cache_en = 1;
        dec_ready = 0;
        flush_pc = 32'h200;
        tick();
        flush_in = 0;
        chk("disc2_rv", 32'(icache_req_valid), 0);
        chk("disc2_dv", 32'(dec_valid), 0);
        rst_in = 1;
        tick();
        rst_in = 0;
        chk("rst2_rv", 32'(icache_req_valid), 0);
        chk("rst2_addr", icache_req_addr, 32'h0);
        chk("rst2_dv", 32'(dec_valid), 0);
        req_log.delete();
        wait_req(1);
        chk("rst2_next", req_log[0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
